// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential divider: operation encoding and FSM states.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIX    = 2'd2,
    DONE   = 2'd3
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring radix-2 sequential divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Handshake: i_start is accepted only when o_busy=0; o_done pulses one cycle with o_result valid.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic                  i_start,
  input  logic                  i_flush,
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [1:0]            o_dbg_state
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  div_state_e    r_state;
  div_state_e    w_next;
  div_op_e       r_op;
  logic          r_neg_a;
  logic          r_neg_b;
  logic [W:0]    r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_dvs;
  logic [W-1:0]  r_result;
  logic [CW-1:0] r_cnt;

  div_op_e       w_op_in;
  logic          w_signed_in;
  logic          w_neg_a_in;
  logic          w_neg_b_in;
  logic [W-1:0]  w_mag_a;
  logic [W-1:0]  w_mag_b;
  logic          w_div_zero;
  logic          w_ovf;
  logic          w_special;
  logic [W-1:0]  w_special_res;
  logic          w_accept;
  logic [W+1:0]  w_shift;
  logic [W+1:0]  w_sub;
  logic          w_restore;
  logic          w_last;
  logic [W-1:0]  w_quo_fix;
  logic [W-1:0]  w_rem_fix;
  logic [W-1:0]  w_fixed;

  // Operand decode in IDLE: signs, magnitudes and the two results that need no iteration.
  assign w_op_in       = div_op_e'(i_op);
  assign w_signed_in   = op_is_signed(w_op_in);
  assign w_neg_a_in    = w_signed_in & i_dividend[W-1];
  assign w_neg_b_in    = w_signed_in & i_divisor[W-1];
  assign w_mag_a       = w_neg_a_in ? (~i_dividend + W'(1)) : i_dividend;
  assign w_mag_b       = w_neg_b_in ? (~i_divisor + W'(1)) : i_divisor;
  assign w_div_zero    = (i_divisor == '0);
  assign w_ovf         = w_signed_in && (i_dividend == {1'b1, {(W-1){1'b0}}}) && (i_divisor == '1);
  assign w_special     = w_div_zero | w_ovf;
  assign w_special_res = op_is_rem(w_op_in) ? (w_div_zero ? i_dividend : '0)
                                            : (w_div_zero ? '1 : i_dividend);
  assign w_accept      = (r_state == IDLE) && i_start && !i_flush;

  // The extra top bit keeps the subtraction sign unambiguous for a full-range divisor.
  assign w_shift   = {r_rem, r_quo[W-1]};
  assign w_sub     = w_shift - {2'b00, r_dvs};
  assign w_restore = w_sub[W+1];
  assign w_last    = (r_cnt == CW'(W - 1));

  assign w_quo_fix = (r_neg_a ^ r_neg_b) ? (~r_quo + W'(1)) : r_quo;
  assign w_rem_fix = r_neg_a ? (~r_rem[W-1:0] + W'(1)) : r_rem[W-1:0];
  assign w_fixed   = op_is_rem(r_op) ? w_rem_fix : w_quo_fix;

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_start) w_next = w_special ? DONE : DIVIDE;
        DIVIDE:  if (w_last) w_next = FIX;
        FIX:     w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy      = (r_state != IDLE);
    o_done      = (r_state == DONE) && !i_flush;
    o_dbg_state = r_state;
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_op     <= OP_DIV;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= w_op_in;
      r_neg_a <= w_neg_a_in;
      r_neg_b <= w_neg_b_in;
      r_quo   <= w_mag_a;
      r_dvs   <= w_mag_b;
      r_rem   <= '0;
      r_cnt   <= '0;
      if (w_special) r_result <= w_special_res;
    end else if ((r_state == DIVIDE) && !i_flush) begin
      r_rem <= w_restore ? w_shift[W:0] : w_sub[W:0];
      r_quo <= {r_quo[W-2:0], ~w_restore};
      r_cnt <= r_cnt + CW'(1);
    end else if ((r_state == FIX) && !i_flush) begin
      r_result <= w_fixed;
    end
  end

  assign o_result = r_result;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus randomized ops vs an arithmetic model.
module tb_seq_divider;

  localparam int W = 64;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic         clk;
  logic         arstn;
  logic         i_start;
  logic         i_flush;
  logic [1:0]   i_op;
  logic [W-1:0] i_dividend;
  logic [W-1:0] i_divisor;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_result;
  logic [1:0]   o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [W-1:0] exp_q[$];

  seq_divider #(.DATA_WIDTH(W)) dut (
    .i_clk       (clk),
    .i_arstn     (arstn),
    .i_start     (i_start),
    .i_flush     (i_flush),
    .i_op        (i_op),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_result    (o_result),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (o_done) done_cnt++;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) || (!op[0] && a == MIN_NEG && b == '1);
  endfunction

  // Reference: plain 64-bit arithmetic, SV signed division truncates toward zero.
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    sa = a;
    sb = b;
    if (b == '0) return op[1] ? a : '1;
    if (!op[0] && a == MIN_NEG && b == '1) return op[1] ? '0 : a;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return {$urandom, $urandom};
      1:       return W'($urandom_range(0, 1000));
      2:       return MIN_NEG;
      3:       return '1;
      4:       return '0;
      default: return {32'($urandom) >> $urandom_range(0, 31), 32'($urandom)};
    endcase
  endfunction

  // Driver: issue one op, wait (bounded) for o_done, score result and latency.
  // With poke set, a second start with other operands is pulsed while busy.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit poke);
    int exp_lat;
    int lat;
    bit seen;
    logic [W-1:0] prev;
    logic [W-1:0] exp;
    exp_q.push_back(model(op, a, b));
    exp_lat = is_special(op, a, b) ? 0 : W + 1;
    prev = o_result;
    seen = 0;
    lat = 0;
    @(negedge clk);
    i_op = op; i_dividend = a; i_divisor = b; i_start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 0) i_start = 1'b0;
      if (poke && k == 5) begin
        i_start = 1'b1; i_dividend = 64'd50; i_divisor = 64'd5; i_op = 2'b01;
      end
      if (poke && k == 6) i_start = 1'b0;
      if (o_done) begin
        seen = 1;
        lat = k;
        break;
      end
      if (k == 1) chk({tag, "_hold"}, o_result, prev);
    end
    exp = exp_q.pop_front();
    chk({tag, "_done_seen"}, W'(seen), W'(1));
    if (seen) begin
      chk({tag, "_latency"}, W'(lat), W'(exp_lat));
      chk({tag, "_result"}, o_result, exp);
      @(negedge clk);
      chk({tag, "_pulse"}, W'(o_done), W'(0));
      chk({tag, "_idle"}, W'(o_busy), W'(0));
      chk({tag, "_keep"}, o_result, exp);
    end
  endtask

  initial begin
    int dc;
    logic [W-1:0] prev;
    logic [1:0] rop;
    arstn = 1'b0; i_start = 1'b0; i_flush = 1'b0; i_op = 2'b00;
    i_dividend = '0; i_divisor = '0;
    #12;
    chk("rst_busy", W'(o_busy), W'(0));
    chk("rst_done", W'(o_done), W'(0));
    chk("rst_result", o_result, '0);
    chk("rst_state", W'(o_dbg_state), W'(0));
    @(negedge clk);
    arstn = 1'b1;

    run_op("divu_100_7", 2'b01, 64'd100, 64'd7, 0);
    run_op("remu_100_7", 2'b11, 64'd100, 64'd7, 0);
    run_op("div_m7_2", 2'b00, -64'sd7, 64'd2, 0);
    chk("div_m7_2_const", o_result, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("rem_m7_2", 2'b10, -64'sd7, 64'd2, 0);
    chk("rem_m7_2_const", o_result, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("div_5_0", 2'b00, 64'd5, 64'd0, 0);
    run_op("rem_5_0", 2'b10, 64'd5, 64'd0, 0);
    chk("rem_5_0_const", o_result, 64'd5);
    run_op("div_ovf", 2'b00, MIN_NEG, '1, 0);
    run_op("rem_ovf", 2'b10, MIN_NEG, '1, 0);
    run_op("divu_max_1", 2'b01, '1, 64'd1, 0);
    run_op("remu_max_max", 2'b11, '1, '1, 0);

    // flush at iteration 10
    prev = o_result;
    dc = done_cnt;
    @(negedge clk);
    i_op = 2'b01; i_dividend = 64'd100; i_divisor = 64'd7; i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    repeat (9) @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    chk("flush_busy", W'(o_busy), W'(0));
    repeat (70) @(negedge clk);
    chk("flush_no_done", W'(done_cnt), W'(dc));
    chk("flush_result", o_result, prev);
    run_op("after_flush_9_3", 2'b01, 64'd9, 64'd3, 0);
    chk("after_flush_const", o_result, 64'd3);

    // async reset at iteration 30
    dc = done_cnt;
    @(negedge clk);
    i_op = 2'b01; i_dividend = 64'd100; i_divisor = 64'd7; i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    repeat (29) @(negedge clk);
    #2 arstn = 1'b0;
    #1;
    chk("arst_busy", W'(o_busy), W'(0));
    chk("arst_done", W'(o_done), W'(0));
    chk("arst_result", o_result, '0);
    chk("arst_state", W'(o_dbg_state), W'(0));
    @(negedge clk);
    arstn = 1'b1;
    repeat (70) @(negedge clk);
    chk("arst_no_done", W'(done_cnt), W'(dc));
    chk("arst_idle", W'(o_busy), W'(0));

    run_op("busy_start_ignored", 2'b01, 64'd1000, 64'd9, 1);
    chk("busy_start_const", o_result, 64'd111);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, rand_operand(), rand_operand(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, operand/result width (even, >= 8).
REQ-002 SHALL have port i_clk  input  1  rising-edge clock.
REQ-003 SHALL have port i_arstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port i_start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port i_flush  input  1  abort in-flight operation (pipeline flush).
REQ-006 SHALL have port i_op  input  2  operation; see REQ-024.
REQ-007 SHALL have port i_dividend  input  DATA_WIDTH  dividend (rs1).
REQ-008 SHALL have port i_divisor  input  DATA_WIDTH  divisor (rs2).
REQ-009 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port o_done  output  1  single-cycle pulse: o_result valid; drives the downstream result register's write enable.
REQ-011 SHALL have port o_result  output  DATA_WIDTH  quotient or remainder per i_op.

Function
REQ-012 SHALL implement FSM states IDLE, DIVIDE, FIX, DONE.
REQ-013 IDLE: i_start=1 and i_flush=0 SHALL latch i_op, operands and operand signs; go to DONE if special case (REQ-019/020), else DIVIDE.
REQ-014 DIVIDE SHALL run restoring radix-2 division on magnitudes: exactly DATA_WIDTH iterations, one quotient bit per cycle, MSB first; iteration counter width $clog2(DATA_WIDTH)+1.
REQ-015 After the last iteration SHALL go to FIX: apply signs (quotient negated when operand signs differ; remainder takes dividend sign), select quotient or remainder into o_result.
REQ-016 FIX SHALL go to DONE; DONE SHALL assert o_done for exactly one cycle, then return to IDLE.
REQ-017 Normal latency: start sampled at edge N -> o_done high in the cycle after edge N+DATA_WIDTH+1.
REQ-018 Special-case latency: o_done high in the cycle after the sampling edge.
REQ-019 Divisor zero: quotient = all ones, remainder = dividend (signed and unsigned).
REQ-020 Signed overflow (dividend = most-negative, divisor = -1, DIV/REM): quotient = dividend, remainder = 0.
REQ-021 i_start while o_busy=1 SHALL be ignored; latched operands SHALL NOT change.
REQ-022 i_flush=1 in any state SHALL return to IDLE on the next edge, suppress o_done, and leave o_result unchanged; i_flush takes priority over i_start in IDLE.
REQ-023 o_result SHALL hold its value from DONE until the next o_done; it updates only on entry to DONE.
REQ-024 i_op encoding: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
REQ-025 Arithmetic: partial remainder DATA_WIDTH+1 bits; subtraction result sign bit selects restore; no width truncation before FIX.

Reset
REQ-026 i_arstn=0 SHALL asynchronously force state IDLE, o_busy=0, o_done=0, o_result=0, counter and all operand registers 0.
REQ-027 Reset deassertion mid-operation SHALL leave the block in IDLE with no o_done pulse; the first accepted i_start thereafter behaves per REQ-013.

Structure
REQ-028 A shared package SHALL hold the 2-bit div-op enum (REQ-024) and the FSM state enum.
REQ-029 No sub-module is needed; the iteration datapath, sign fix and output register SHALL be inline in seq_divider.

Verification (DATA_WIDTH=64)
REQ-030 DIVU 100/7 -> o_result=14, o_done 66 cycles after start; REMU 100/7 -> 2.
REQ-031 DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF (-1).
REQ-032 DIV 5/0 -> 0xFFFF_FFFF_FFFF_FFFF, REM 5/0 -> 5; o_done one cycle after start.
REQ-033 DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM same -> 0; one-cycle latency.
REQ-034 DIVU 100/7, i_flush at iteration 10 -> no o_done, o_busy low next cycle, o_result unchanged; immediate DIVU 9/3 -> 3.
REQ-035 i_arstn low at iteration 30, then released -> outputs 0, IDLE; second i_start during a running op ignored (result matches first op).
